carry_skip_accumulator: RTL and testbench

Sequential front-end that feeds `carry_skip_32bit_adder`: it accepts a programmed-length stream of 32-bit operands over a valid/ready handshake and folds them into a running sum. Each cycle it drives the adder with the accumulator register and one operand, then registers the result. The final sum and a count of carry-outs are presented on a valid/ready output port. It is the first sequential stage wrapped around the ADDERS datapath.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/carry_skip_32bit_adder.sv | 40 ++++
 rtl/carry_skip_accumulator.sv | 87 ++++++++
 tb/tb_carry_skip_accumulator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared widths, FSM state type and result payload for the adder datapath blocks.
package adder_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BLK_W = 4;
  localparam int unsigned N_BLK = WIDTH / BLK_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] carries;
  } acc_result_t;

endpackage

// File: rtl/carry_skip_32bit_adder.sv
// 32-bit carry-skip adder: 4-bit ripple blocks, each bypassed when all its bits propagate.
module carry_skip_32bit_adder
  import adder_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic             c_blk;
  logic             c_rip;
  logic             p_blk;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  // Ripple inside a block; the block carry-out skips the ripple when the block fully propagates.
  always_comb begin
    sum   = '0;
    c_blk = cin;
    c_rip = 1'b0;
    p_blk = 1'b0;
    for (int blk = 0; blk < int'(N_BLK); blk++) begin
      c_rip = c_blk;
      p_blk = 1'b1;
      for (int i = 0; i < int'(BLK_W); i++) begin
        sum[blk*BLK_W + i] = p[blk*BLK_W + i] ^ c_rip;
        c_rip              = g[blk*BLK_W + i] | (p[blk*BLK_W + i] & c_rip);
        p_blk              = p_blk & p[blk*BLK_W + i];
      end
      c_blk = p_blk ? c_blk : c_rip;
    end
    cout = c_blk;
  end

endmodule

// File: rtl/carry_skip_accumulator.sv
// Folds a programmed-length operand stream into a running sum via one carry-skip adder.
module carry_skip_accumulator
  import adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             busy
);

  acc_state_t       state, state_d;
  acc_result_t      res, res_d;
  logic [CNT_W-1:0] remain, remain_d;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  carry_skip_32bit_adder u_adder (
    .a    (res.sum),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath update; in_ready mirrors state==ACCUM.
  always_comb begin
    state_d  = state;
    res_d    = res;
    remain_d = remain;
    case (state)
      IDLE: begin
        if (start) begin
          res_d = '0;
          if (len != '0) begin
            remain_d = len;
            state_d  = ACCUM;
          end else begin
            state_d = HOLD;
          end
        end
      end
      ACCUM: begin
        if (in_valid && in_ready) begin
          res_d.sum     = add_sum;
          res_d.carries = res.carries + CNT_W'(add_cout);
          remain_d      = remain - CNT_W'(1);
          if (remain == CNT_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and handshake flags, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      res       <= '0;
      remain    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      res       <= res_d;
      remain    <= remain_d;
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == HOLD);
      busy      <= (state_d != IDLE);
    end
  end

  assign out_sum     = res.sum;
  assign out_carries = res.carries;

endmodule

// File: tb/tb_carry_skip_accumulator.sv
// Directed bench for carry_skip_accumulator with a queue-based result scoreboard.
module tb_carry_skip_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_carries;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  carries;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  carry_skip_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops an expected result on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%h/%0d required=none", out_sum, out_carries);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_sum !== e.sum || out_carries !== e.carries) begin
          errors++;
          $display("FAIL result actual=%h/%0d required=%h/%0d",
                   out_sum, out_carries, e.sum, e.carries);
        end
      end
    end
  end

  task automatic start_job(input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one operand and return just after the edge that consumed it.
  task automatic send(input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Two back-to-back operands, no carry; out_valid three edges after start is driven.
    exp_q.push_back('{32'h23456789, 8'd0});
    start_job(8'd2);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    send(32'h12345678);
    chk("t1_mid_valid", 32'(out_valid), 32'd0);
    send(32'h11111111);
    chk("t1_latency", 32'(out_valid), 32'd1);
    wait_idle();

    // Wrap to zero with one carry.
    exp_q.push_back('{32'h00000000, 8'd1});
    start_job(8'd2);
    send(32'hFFFFFFFF);
    send(32'h00000001);
    wait_idle();

    // Gaps of two cycles between operands.
    exp_q.push_back('{32'h00000000, 8'd1});
    start_job(8'd3);
    send(32'hAAAAAAAA);
    repeat (2) begin
      @(posedge clk); #1;
      chk("t3_gap_ready", 32'(in_ready), 32'd1);
      chk("t3_gap_valid", 32'(out_valid), 32'd0);
    end
    send(32'h55555555);
    repeat (2) @(posedge clk);
    #1;
    send(32'h00000001);
    wait_idle();

    // len==0 goes straight to HOLD; stalled output stays stable and start is ignored.
    out_ready = 1'b0;
    start_job(8'd0);
    chk("t4_valid_next", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      len   = 8'd5;
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_sum", out_sum, 32'd0);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
    end
    start = 1'b0;
    exp_q.push_back('{32'h00000000, 8'd0});
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_back_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-stream discards the partial sum.
    start_job(8'd4);
    send(32'h00000001);
    send(32'h00000002);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sum", out_sum, 32'd0);
    chk("t5_rst_carries", 32'(out_carries), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    exp_q.push_back('{32'h0F0F0F0F, 8'd0});
    start_job(8'd1);
    send(32'h0F0F0F0F);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
